// File: rtl/pulse_pkg.sv
// Shared types for the pulse-counting run-control: sequencer states and result status codes.
package pulse_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned TMO_W_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_REPORT  = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    ST_TARGET  = 2'b00,
    ST_STOP    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_RSVD    = 2'b11
  } res_status_e;

endpackage

// File: rtl/capture_timer.sv
// Clearable up-counter with a combinational terminal-match flag; times both the ARM hold and the capture timeout.
module capture_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         match_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign match_c = (cnt_q == term);

endmodule

// File: rtl/capture_sequencer.sv
// Run-control for the pulse counter: arm, capture until target/stop/timeout, then hand the
// latched count to readout over a valid/ready port.
module capture_sequencer
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF,
  parameter int unsigned ARM_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic [CNT_W-1:0] target_count,
  input  logic [TMO_W-1:0] timeout_cycles,
  input  logic             SPEC_Acc_Done,
  input  logic [CNT_W-1:0] Pulse_counts,
  output logic             Capture_En,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_count,
  output logic [1:0]       res_status
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [TMO_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] count_d;
  res_status_e      status_q, status_d;

  logic             tmr_clr_c, tmr_inc_c, tmr_match_c;
  logic [TMO_W-1:0] tmr_term_c;
  logic             exit_c, target_hit_c, timeout_hit_c;

  // Done pulses are already folded into Pulse_counts by the counter; only observed here.
  logic unused_acc_done;
  assign unused_acc_done = SPEC_Acc_Done;

  assign tmr_term_c    = (state_q == S_ARM) ? TMO_W'(ARM_CYCLES - 1) : (timeout_q - TMO_W'(1));
  assign target_hit_c  = (target_q != '0) && (Pulse_counts >= target_q);
  assign timeout_hit_c = (timeout_q != '0) && tmr_match_c;

  capture_timer #(.W(TMO_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr_c),
    .inc     (tmr_inc_c),
    .term    (tmr_term_c),
    .match_c (tmr_match_c)
  );

  // Next-state, run parameters and result capture
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    count_d   = res_count;
    status_d  = status_q;
    tmr_clr_c = 1'b0;
    tmr_inc_c = 1'b0;
    exit_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          target_d  = target_count;
          timeout_d = timeout_cycles;
          tmr_clr_c = 1'b1;
          state_d   = S_ARM;
        end
      end

      S_ARM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_match_c) begin
          tmr_clr_c = 1'b1;
          state_d   = S_CAPTURE;
        end else begin
          tmr_inc_c = 1'b1;
        end
      end

      S_CAPTURE: begin
        tmr_inc_c = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (stop) begin
            exit_c   = 1'b1;
            status_d = ST_STOP;
          end else if (target_hit_c) begin
            exit_c   = 1'b1;
            status_d = ST_TARGET;
          end else if (timeout_hit_c) begin
            exit_c   = 1'b1;
            status_d = ST_TIMEOUT;
          end
          if (exit_c) begin
            count_d = Pulse_counts;
            state_d = S_REPORT;
          end
        end
      end

      S_REPORT: begin
        if (abort || res_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      timeout_q  <= '0;
      res_count  <= '0;
      status_q   <= ST_TARGET;
      Capture_En <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      timeout_q  <= timeout_d;
      res_count  <= count_d;
      status_q   <= status_d;
      Capture_En <= (state_d == S_CAPTURE);
      busy       <= (state_d != S_IDLE);
      res_valid  <= (state_d == S_REPORT);
    end
  end

  assign res_status = status_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed and randomized runs of capture_sequencer against a pulse-count/exit-rule model.
module tb_capture_sequencer;
  import pulse_pkg::*;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned TMO_W      = 32;
  localparam int unsigned ARM_CYCLES = 2;
  localparam int          MAX_CAP    = 1000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             abort;
  logic [CNT_W-1:0] target_count;
  logic [TMO_W-1:0] timeout_cycles;
  logic             SPEC_Acc_Done;
  logic [CNT_W-1:0] Pulse_counts;
  logic             Capture_En;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [1:0]       res_status;

  int errors = 0;
  int checks = 0;

  capture_sequencer #(
    .CNT_W      (CNT_W),
    .TMO_W      (TMO_W),
    .ARM_CYCLES (ARM_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .abort          (abort),
    .target_count   (target_count),
    .timeout_cycles (timeout_cycles),
    .SPEC_Acc_Done  (SPEC_Acc_Done),
    .Pulse_counts   (Pulse_counts),
    .Capture_En     (Capture_En),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_count      (res_count),
    .res_status     (res_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One run. The environment plays the pulse counter: Pulse_counts in capture cycle k equals the
  // Done pulses driven in cycles 0..k-1. Expected exit is the first k meeting stop, target or timeout.
  task automatic run(input int tgt, input int tmo, input int sp, input int stop_at,
                     input int abort_at, input int hold, input bit rpt_abort,
                     input bit start_abort, input string nm);
    int          n;
    int          k;
    bit          exited;
    bit          done;
    logic [1:0]  est;
    logic [15:0] ecnt;
    n      = 0;
    exited = 1'b0;
    est    = 2'b00;
    ecnt   = '0;
    target_count   = CNT_W'(tgt);
    timeout_cycles = TMO_W'(tmo);
    Pulse_counts   = '0;
    start = 1'b1;
    abort = start_abort;
    step();
    start = 1'b0;
    abort = 1'b0;
    target_count   = CNT_W'($urandom);
    timeout_cycles = TMO_W'($urandom);
    for (int i = 0; i < int'(ARM_CYCLES); i++) begin
      chk($sformatf("%s_arm_busy", nm), 32'(busy), 32'd1);
      chk($sformatf("%s_arm_en", nm), 32'(Capture_En), 32'd0);
      step();
    end
    for (k = 0; k < MAX_CAP; k++) begin
      chk($sformatf("%s_cap_en_k%0d", nm, k), 32'(Capture_En), 32'd1);
      chk($sformatf("%s_cap_valid_k%0d", nm, k), 32'(res_valid), 32'd0);
      done = (sp == 0) ? ($urandom_range(0, 2) == 0) : ((k % sp) == sp - 1);
      Pulse_counts  = CNT_W'(n);
      SPEC_Acc_Done = done;
      stop          = (k == stop_at);
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        stop = 1'b0;
        SPEC_Acc_Done = 1'b0;
        Pulse_counts = '0;
        chk($sformatf("%s_abort_busy", nm), 32'(busy), 32'd0);
        chk($sformatf("%s_abort_en", nm), 32'(Capture_En), 32'd0);
        chk($sformatf("%s_abort_valid", nm), 32'(res_valid), 32'd0);
        repeat (3) begin
          step();
          chk($sformatf("%s_abort_valid_after", nm), 32'(res_valid), 32'd0);
        end
        return;
      end
      if (k == stop_at) begin
        exited = 1'b1;
        est    = ST_STOP;
      end else if (tgt != 0 && n >= tgt) begin
        exited = 1'b1;
        est    = ST_TARGET;
      end else if (tmo != 0 && k == tmo - 1) begin
        exited = 1'b1;
        est    = ST_TIMEOUT;
      end
      ecnt = 16'(n);
      step();
      if (exited) break;
      if (done) n++;
    end
    stop = 1'b0;
    SPEC_Acc_Done = 1'b0;
    Pulse_counts = '0;
    if (!exited) begin
      errors++;
      checks++;
      $error("FAIL %s_bound: observed=no exit expected=exit within %0d cycles", nm, MAX_CAP);
      return;
    end
    chk($sformatf("%s_exit_valid", nm), 32'(res_valid), 32'd1);
    chk($sformatf("%s_exit_en", nm), 32'(Capture_En), 32'd0);
    chk($sformatf("%s_exit_busy", nm), 32'(busy), 32'd1);
    chk($sformatf("%s_exit_count", nm), 32'(res_count), 32'(ecnt));
    chk($sformatf("%s_exit_status", nm), 32'(res_status), 32'(est));
    for (int h = 0; h < hold; h++) begin
      res_ready    = 1'b0;
      start        = (h == hold / 2);
      Pulse_counts = CNT_W'($urandom);
      step();
      chk($sformatf("%s_hold_valid", nm), 32'(res_valid), 32'd1);
      chk($sformatf("%s_hold_count", nm), 32'(res_count), 32'(ecnt));
      chk($sformatf("%s_hold_status", nm), 32'(res_status), 32'(est));
    end
    start        = 1'b0;
    Pulse_counts = '0;
    abort        = rpt_abort;
    res_ready    = 1'b1;
    step();
    abort     = 1'b0;
    res_ready = 1'b0;
    chk($sformatf("%s_done_valid", nm), 32'(res_valid), 32'd0);
    chk($sformatf("%s_done_busy", nm), 32'(busy), 32'd0);
    chk($sformatf("%s_done_en", nm), 32'(Capture_En), 32'd0);
    step();
    chk($sformatf("%s_idle_busy", nm), 32'(busy), 32'd0);
  endtask

  initial begin
    int tgt;
    int tmo;
    int stp;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    abort = 1'b0;
    target_count = '0;
    timeout_cycles = '0;
    SPEC_Acc_Done = 1'b0;
    Pulse_counts = '0;
    res_ready = 1'b0;
    #3;
    chk("rst_en", 32'(Capture_En), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(res_count), 32'd0);
    chk("rst_status", 32'(res_status), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // stop/abort while idle do nothing
    abort = 1'b1;
    stop  = 1'b1;
    step();
    abort = 1'b0;
    stop  = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    chk("idle_abort_valid", 32'(res_valid), 32'd0);

    run(5, 0, 10, -1, -1, 3, 1'b0, 1'b0, "t1_target");
    run(0, 100, 30, -1, -1, 2, 1'b0, 1'b0, "t2_timeout");
    run(0, 0, 3, 21, -1, 20, 1'b0, 1'b0, "t3_stop");

    // asynchronous reset mid-capture
    target_count   = '0;
    timeout_cycles = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (ARM_CYCLES) step();
    Pulse_counts = 16'd3;
    repeat (4) step();
    chk("rc_en_before", 32'(Capture_En), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_en", 32'(Capture_En), 32'd0);
    chk("rc_busy", 32'(busy), 32'd0);
    chk("rc_valid", 32'(res_valid), 32'd0);
    chk("rc_count", 32'(res_count), 32'd0);
    chk("rc_status", 32'(res_status), 32'd0);
    #2 rst_n = 1'b1;
    Pulse_counts = '0;
    repeat (3) begin
      step();
      chk("rc_after_busy", 32'(busy), 32'd0);
      chk("rc_after_en", 32'(Capture_En), 32'd0);
    end

    run(0, 0, 5, -1, 12, 0, 1'b0, 1'b0, "t4_abort_cap");
    run(0, 0, 5, 13, -1, 0, 1'b1, 1'b0, "t4_abort_rpt");
    run(3, 0, 2, 6, -1, 1, 1'b0, 1'b0, "t5_stop_vs_target");
    run(0, 0, 4, 11, -1, 1, 1'b0, 1'b0, "t5_done_at_exit");
    run(2, 0, 3, -1, -1, 0, 1'b0, 1'b1, "t_start_with_abort");

    for (int r = 0; r < 10; r++) begin
      tgt = int'($urandom_range(0, 8));
      tmo = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 60)) : 0;
      stp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 80)) : -1;
      if (tgt == 0 && tmo == 0 && stp < 0) stp = 40;
      run(tgt, tmo, 0, stp, -1, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
